// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared opcodes, datapath encodings and FSM state type for the UART command sequencer.
package uart_cmd_sequencer_pkg;

   localparam logic [7:0] OPC_ADD = 8'h00;
   localparam logic [7:0] OPC_MUL = 8'h01;
   localparam logic [7:0] OPC_MAC = 8'h02;
   localparam logic [7:0] OPC_RET = 8'h03;

   localparam logic [1:0] DP_ADD = 2'd0;
   localparam logic [1:0] DP_MUL = 2'd1;

   typedef enum logic [1:0] {
      CMD_ADD = 2'd0,
      CMD_MUL = 2'd1,
      CMD_MAC = 2'd2,
      CMD_RET = 2'd3
   } cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_GET_A     = 3'd1,
      ST_GET_B     = 3'd2,
      ST_EXEC      = 3'd3,
      ST_WAIT_OP   = 3'd4,
      ST_SEND      = 3'd5,
      ST_SEND_WAIT = 3'd6
   } state_t;

   function automatic logic is_valid_opc(input logic [7:0] opc);
      return (opc <= OPC_RET);
   endfunction

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// Bundle of UART byte, TX handshake and datapath signals around the command sequencer.
interface uart_cmd_sequencer_if #(
   parameter int OP_W = 16
);
   logic [7:0]        rx_byte;
   logic              rx_done;
   logic [7:0]        tx_byte;
   logic              tx_start;
   logic              tx_busy;
   logic              tx_done;
   logic              op_start;
   logic [1:0]        op_code;
   logic [OP_W-1:0]   op_a;
   logic [OP_W-1:0]   op_b;
   logic              op_done;
   logic [2*OP_W-1:0] op_result;
   logic              busy;
   logic              err;

   modport slave (
      input  rx_byte, rx_done, tx_busy, tx_done, op_done, op_result,
      output tx_byte, tx_start, op_start, op_code, op_a, op_b, busy, err
   );

   modport master (
      output rx_byte, rx_done, tx_busy, tx_done, op_done, op_result,
      input  tx_byte, tx_start, op_start, op_code, op_a, op_b, busy, err
   );
endinterface

// File: rtl/uart_byte_serializer.sv
// Result shift register feeding uart_tx one byte at a time, MSB first.
module uart_byte_serializer #(
   parameter int ACC_W = 40
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [ACC_W-1:0] load_data,
   input  logic             send_en,
   input  logic             wait_en,
   input  logic             tx_busy,
   input  logic             tx_done,
   output logic [7:0]       tx_byte,
   output logic             tx_start,
   output logic             fire,
   output logic             byte_done,
   output logic             last
);
   localparam int RB    = ACC_W / 8;
   localparam int CNT_W = $clog2(RB + 1);

   logic [ACC_W-1:0] shift_r;
   logic [CNT_W-1:0] cnt_r;
   logic [7:0]       tx_byte_r;
   logic             tx_start_r;

   assign fire      = send_en & ~tx_busy;
   assign byte_done = wait_en & tx_done;
   assign last      = (cnt_r == CNT_W'(RB - 1));
   assign tx_byte   = tx_byte_r;
   assign tx_start  = tx_start_r;

   // Shift register, sent-byte counter and registered TX strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_r    <= '0;
         cnt_r      <= '0;
         tx_byte_r  <= 8'h00;
         tx_start_r <= 1'b0;
      end else begin
         tx_start_r <= fire;
         tx_byte_r  <= fire ? shift_r[ACC_W-1 -: 8] : 8'h00;
         if (load) begin
            shift_r <= load_data;
            cnt_r   <= '0;
         end else if (byte_done) begin
            shift_r <= shift_r << 8;
            cnt_r   <= cnt_r + CNT_W'(1);
         end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
         end
      end
   end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Parses opcode/operand bytes from the host, launches one datapath op, accumulates
// MAC products and returns results MSB first through uart_tx.
module uart_cmd_sequencer
   import uart_cmd_sequencer_pkg::*;
#(
   parameter int OP_W         = 16,
   parameter int ACC_W        = 40,
   parameter int TIMEOUT_CLKS = 100000
) (
   input logic                 clk,
   input logic                 rst,
   uart_cmd_sequencer_if.slave bus
);
   localparam int NB    = OP_W / 8;
   localparam int BC_W  = $clog2(NB + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

   state_t           state_r;
   state_t           state_s;
   cmd_t             cmd_r;
   logic [OP_W-1:0]  a_r;
   logic [OP_W-1:0]  b_r;
   logic [BC_W-1:0]  byte_cnt_r;
   logic [TMO_W-1:0] tmo_cnt_r;
   logic [ACC_W-1:0] acc_r;
   logic [1:0]       op_code_r;
   logic             op_start_r;
   logic             busy_r;
   logic             err_r;

   logic             in_get_s;
   logic             last_byte_s;
   logic             tmo_hit_s;
   logic             start_cmd_s;
   logic             ret_cmd_s;
   logic             mac_done_s;
   logic             err_s;
   logic             ser_load_s;
   logic [ACC_W-1:0] ser_data_s;
   logic             ser_fire_s;
   logic             ser_byte_done_s;
   logic             ser_last_s;

   assign in_get_s    = (state_r == ST_GET_A) || (state_r == ST_GET_B);
   assign last_byte_s = (byte_cnt_r == BC_W'(NB - 1));
   // A byte arriving on the expiry cycle takes priority over the timeout
   assign tmo_hit_s   = in_get_s && !bus.rx_done && (tmo_cnt_r == TMO_W'(TIMEOUT_CLKS - 1));
   assign start_cmd_s = (state_r == ST_IDLE) && bus.rx_done && is_valid_opc(bus.rx_byte)
                        && (bus.rx_byte != OPC_RET);
   assign ret_cmd_s   = (state_r == ST_IDLE) && bus.rx_done && (bus.rx_byte == OPC_RET);
   assign mac_done_s  = (state_r == ST_WAIT_OP) && bus.op_done && (cmd_r == CMD_MAC);

   // Next-state, error strobe and serializer load
   always_comb begin
      state_s    = state_r;
      err_s      = 1'b0;
      ser_load_s = 1'b0;
      ser_data_s = '0;
      case (state_r)
         ST_IDLE: begin
            if (ret_cmd_s) begin
               state_s    = ST_SEND;
               ser_load_s = 1'b1;
               ser_data_s = acc_r;
            end else if (start_cmd_s) begin
               state_s = ST_GET_A;
            end else if (bus.rx_done) begin
               err_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_GET_A, ST_GET_B: begin
            if (bus.rx_done) begin
               if (last_byte_s) begin
                  state_s = (state_r == ST_GET_A) ? ST_GET_B : ST_EXEC;
               end else begin
                  state_s = state_r;
               end
            end else if (tmo_hit_s) begin
               state_s = ST_IDLE;
               err_s   = 1'b1;
            end else begin
               state_s = state_r;
            end
         end
         ST_EXEC: begin
            err_s   = bus.rx_done;
            state_s = ST_WAIT_OP;
         end
         ST_WAIT_OP: begin
            err_s = bus.rx_done;
            if (bus.op_done) begin
               if (cmd_r == CMD_MAC) begin
                  state_s = ST_IDLE;
               end else begin
                  state_s    = ST_SEND;
                  ser_load_s = 1'b1;
                  ser_data_s = ACC_W'(bus.op_result);
               end
            end else begin
               state_s = ST_WAIT_OP;
            end
         end
         ST_SEND: begin
            err_s = bus.rx_done;
            if (ser_fire_s) begin
               state_s = ST_SEND_WAIT;
            end else begin
               state_s = ST_SEND;
            end
         end
         ST_SEND_WAIT: begin
            err_s = bus.rx_done;
            if (ser_byte_done_s) begin
               state_s = ser_last_s ? ST_IDLE : ST_SEND;
            end else begin
               state_s = ST_SEND_WAIT;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State register with registered status strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         busy_r     <= 1'b0;
         op_start_r <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         busy_r     <= (state_s != ST_IDLE);
         op_start_r <= (state_s == ST_EXEC);
         err_r      <= err_s;
      end
   end

   // Latch the command kind and datapath encoding at opcode decode
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_r     <= CMD_ADD;
         op_code_r <= DP_ADD;
      end else if (start_cmd_s) begin
         cmd_r     <= cmd_t'(bus.rx_byte[1:0]);
         op_code_r <= (bus.rx_byte == OPC_ADD) ? DP_ADD : DP_MUL;
      end else begin
         cmd_r     <= cmd_r;
         op_code_r <= op_code_r;
      end
   end

   // Operand deserializer, first byte lands in the MSBs
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r        <= '0;
         b_r        <= '0;
         byte_cnt_r <= '0;
      end else if (in_get_s && bus.rx_done) begin
         if (state_r == ST_GET_A) begin
            a_r <= OP_W'({a_r, bus.rx_byte});
         end else begin
            b_r <= OP_W'({b_r, bus.rx_byte});
         end
         byte_cnt_r <= last_byte_s ? '0 : (byte_cnt_r + BC_W'(1));
      end else if (state_r == ST_IDLE) begin
         byte_cnt_r <= '0;
      end else begin
         byte_cnt_r <= byte_cnt_r;
      end
   end

   // Inter-byte idle counter, only live while collecting operands
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_r <= '0;
      end else if (!in_get_s || bus.rx_done) begin
         tmo_cnt_r <= '0;
      end else begin
         tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end
   end

   // MAC accumulator, wraps silently and is cleared when read out by RET
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r <= '0;
      end else if (ret_cmd_s) begin
         acc_r <= '0;
      end else if (mac_done_s) begin
         acc_r <= acc_r + ACC_W'(bus.op_result);
      end else begin
         acc_r <= acc_r;
      end
   end

   uart_byte_serializer #(
      .ACC_W (ACC_W)
   ) u_serializer (
      .clk       (clk),
      .rst       (rst),
      .load      (ser_load_s),
      .load_data (ser_data_s),
      .send_en   (state_r == ST_SEND),
      .wait_en   (state_r == ST_SEND_WAIT),
      .tx_busy   (bus.tx_busy),
      .tx_done   (bus.tx_done),
      .tx_byte   (bus.tx_byte),
      .tx_start  (bus.tx_start),
      .fire      (ser_fire_s),
      .byte_done (ser_byte_done_s),
      .last      (ser_last_s)
   );

   assign bus.op_start = op_start_r;
   assign bus.op_code  = op_code_r;
   assign bus.op_a     = a_r;
   assign bus.op_b     = b_r;
   assign bus.busy     = busy_r;
   assign bus.err      = err_r;

endmodule
